// File: rtl/servo_pwm_multi_if.sv
// Bus-slave register access for the servo PWM block.
// A transfer happens only when a strobe and servo_en are both high.
// bus_read_data is combinational and reads as 0 when no read is active.
interface servo_pwm_multi_if;
  logic        bus_write_en;
  logic        bus_read_en;
  logic        servo_en;
  logic [7:0]  bus_addr;
  logic [31:0] bus_write_data;
  logic [31:0] bus_read_data;

  modport master (
    output bus_write_en,
    output bus_read_en,
    output servo_en,
    output bus_addr,
    output bus_write_data,
    input  bus_read_data
  );

  modport slave (
    input  bus_write_en,
    input  bus_read_en,
    input  servo_en,
    input  bus_addr,
    input  bus_write_data,
    output bus_read_data
  );
endinterface

// File: rtl/servo_pwm_multi.sv
// Multi-channel RC-servo PWM generator.
// All channels share one period counter. Pulse targets are clamped on write
// and only reach the active width at the period boundary, optionally
// slew-limited by STEP counts per period, so outputs never glitch mid-period.
module servo_pwm_multi #(
  parameter int NUM_CH    = 4,
  parameter int PERIOD    = 500000,
  parameter int CNT_W     = 20,
  parameter int MIN_PULSE = 50000,
  parameter int MAX_PULSE = 100000
) (
  input  logic              pclk,
  input  logic              nreset,
  servo_pwm_multi_if.slave  bus,
  output logic [NUM_CH-1:0] servo_out
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] MIN_P    = CNT_W'(MIN_PULSE);
  localparam logic [CNT_W-1:0] MAX_P    = CNT_W'(MAX_PULSE);

  localparam logic [5:0] A_CTRL   = 6'h10;
  localparam logic [5:0] A_STEP   = 6'h11;
  localparam logic [5:0] A_STATUS = 6'h12;
  localparam logic [5:0] A_COUNT  = 6'h13;

  logic [CNT_W-1:0]  counter;
  logic [CNT_W-1:0]  target      [NUM_CH];
  logic [CNT_W-1:0]  active      [NUM_CH];
  logic [CNT_W-1:0]  next_active [NUM_CH];
  logic [NUM_CH-1:0] ctrl;
  logic [NUM_CH-1:0] en_act;
  logic [NUM_CH-1:0] status;
  logic [CNT_W-1:0]  step;
  logic [CNT_W-1:0]  wr_clamped;
  logic [31:0]       rdata;

  logic       wr_acc;
  logic       rd_acc;
  logic       boundary;
  logic [5:0] word_addr;
  logic       unused_bits;

  assign wr_acc      = bus.bus_write_en & bus.servo_en;
  assign rd_acc      = bus.bus_read_en & bus.servo_en;
  assign word_addr   = bus.bus_addr[7:2];
  assign boundary    = (counter == LAST_CNT);
  assign unused_bits = ^{bus.bus_addr[1:0], bus.bus_write_data[31:CNT_W]};

  // Clamp incoming pulse width into the legal servo range.
  always_comb begin
    wr_clamped = bus.bus_write_data[CNT_W-1:0];
    if (bus.bus_write_data[CNT_W-1:0] < MIN_P) begin
      wr_clamped = MIN_P;
    end else if (bus.bus_write_data[CNT_W-1:0] > MAX_P) begin
      wr_clamped = MAX_P;
    end
  end

  // Shared period counter, 0..PERIOD-1.
  always_ff @(posedge pclk) begin
    if (!nreset) begin
      counter <= '0;
    end else if (boundary) begin
      counter <= '0;
    end else begin
      counter <= counter + 1'b1;
    end
  end

  // Slew-limited step of each active width toward its target, one period's worth.
  always_comb begin
    logic [CNT_W:0] t_ext;
    logic [CNT_W:0] a_ext;
    logic [CNT_W:0] s_ext;
    logic [CNT_W:0] diff;
    t_ext = '0;
    a_ext = '0;
    s_ext = {1'b0, step};
    diff  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      next_active[i] = active[i];
      t_ext = {1'b0, target[i]};
      a_ext = {1'b0, active[i]};
      diff  = (t_ext >= a_ext) ? (t_ext - a_ext) : (a_ext - t_ext);
      if (step == '0 || diff <= s_ext) begin
        next_active[i] = target[i];
      end else if (t_ext > a_ext) begin
        next_active[i] = CNT_W'(a_ext + s_ext);
      end else begin
        next_active[i] = CNT_W'(a_ext - s_ext);
      end
    end
  end

  // Boundary transfer of config into the active set; reads old register values.
  always_ff @(posedge pclk) begin
    if (!nreset) begin
      en_act <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        active[i] <= MIN_P;
      end
    end else if (boundary) begin
      en_act <= ctrl;
      for (int i = 0; i < NUM_CH; i++) begin
        active[i] <= next_active[i];
      end
    end
  end

  // Bus-writable configuration registers.
  always_ff @(posedge pclk) begin
    if (!nreset) begin
      ctrl <= '0;
      step <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        target[i] <= MIN_P;
      end
    end else if (wr_acc) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (word_addr == 6'(i)) begin
          target[i] <= wr_clamped;
        end
      end
      if (word_addr == A_CTRL) begin
        ctrl <= bus.bus_write_data[NUM_CH-1:0];
      end
      if (word_addr == A_STEP) begin
        step <= bus.bus_write_data[CNT_W-1:0];
      end
    end
  end

  // Per-channel flag: active width has not yet reached its target.
  always_comb begin
    status = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      status[i] = (active[i] != target[i]);
    end
  end

  // Combinational read mux; zero when idle or unmapped.
  always_comb begin
    rdata = '0;
    if (rd_acc) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (word_addr == 6'(i)) begin
          rdata = 32'(target[i]);
        end
      end
      case (word_addr)
        A_CTRL:   rdata = 32'(ctrl);
        A_STEP:   rdata = 32'(step);
        A_STATUS: rdata = 32'(status);
        A_COUNT:  rdata = 32'(counter);
        default:  ;
      endcase
    end
  end

  assign bus.bus_read_data = rdata;

  // Registered PWM outputs: high while counter is below the active width.
  always_ff @(posedge pclk) begin
    if (!nreset) begin
      servo_out <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        servo_out[i] <= en_act[i] & (counter < active[i]);
      end
    end
  end

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Self-checking bench for servo_pwm_multi (2 channels, 100-cycle period, 10..40 pulse).
// Register accesses come from a vector table; multi-period behaviour is
// checked by measuring pulse widths against a scoreboard queue.
module tb_servo_pwm_multi;
  localparam int NUM_CH = 2;
  localparam int PERIOD = 100;
  localparam int CNT_W  = 8;
  localparam int MINP   = 10;
  localparam int MAXP   = 40;

  logic              pclk = 1'b0;
  logic              nreset = 1'b0;
  logic [NUM_CH-1:0] servo_out;

  servo_pwm_multi_if bus_if ();

  servo_pwm_multi #(
    .NUM_CH(NUM_CH), .PERIOD(PERIOD), .CNT_W(CNT_W),
    .MIN_PULSE(MINP), .MAX_PULSE(MAXP)
  ) dut (
    .pclk(pclk),
    .nreset(nreset),
    .bus(bus_if),
    .servo_out(servo_out)
  );

  // Clock and watchdog.
  always #5 pclk = ~pclk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Bench-side period counter model.
  int tb_cnt;
  always @(posedge pclk) begin
    if (!nreset) tb_cnt <= 0;
    else         tb_cnt <= (tb_cnt == PERIOD - 1) ? 0 : tb_cnt + 1;
  end

  // Scoreboard.
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];

  task automatic sb_check(input string name, input logic [31:0] act);
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: got %0d, no expected value queued", name, act);
      return;
    end
    e = exp_q.pop_front();
    if (act !== e) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, e);
    end
  endtask

  // Driver tasks: entered at a negedge, return at a negedge.
  task automatic bus_write(input logic en, input logic [7:0] addr, input logic [31:0] data);
    bus_if.servo_en       = en;
    bus_if.bus_addr       = addr;
    bus_if.bus_write_data = data;
    bus_if.bus_write_en   = 1'b1;
    @(negedge pclk);
    bus_if.bus_write_en   = 1'b0;
    bus_if.servo_en       = 1'b0;
  endtask

  task automatic bus_read(input logic en, input logic [7:0] addr, output logic [31:0] data);
    bus_if.servo_en    = en;
    bus_if.bus_addr    = addr;
    bus_if.bus_read_en = 1'b1;
    #1;
    data = bus_if.bus_read_data;
    bus_if.bus_read_en = 1'b0;
    bus_if.servo_en    = 1'b0;
    @(negedge pclk);
  endtask

  task automatic wait_cnt(input int v);
    int n;
    n = 0;
    while (tb_cnt != v && n < 3 * PERIOD) begin
      @(negedge pclk);
      n++;
    end
    if (tb_cnt != v) begin
      checks++;
      errors++;
      $display("FAIL wait_cnt: counter %0d never reached, at %0d", v, tb_cnt);
    end
  endtask

  // Measure one full period of output (counter 1..0); act 1 = read STATUS at
  // sample act_j, act 2 = write CTRL=0 at sample act_j.
  task automatic measure(input int act_j, input int act,
                         output int w0, output int w1, output logic [31:0] st);
    w0 = 0; w1 = 0; st = '0;
    wait_cnt(1);
    for (int j = 0; j < PERIOD; j++) begin
      bus_if.bus_write_en = 1'b0;
      if (servo_out[0]) w0++;
      if (servo_out[1]) w1++;
      if (j == act_j && act == 1) begin
        bus_if.servo_en    = 1'b1;
        bus_if.bus_addr    = 8'h48;
        bus_if.bus_read_en = 1'b1;
        #1;
        st = bus_if.bus_read_data;
        bus_if.bus_read_en = 1'b0;
      end else if (j == act_j && act == 2) begin
        bus_if.servo_en       = 1'b1;
        bus_if.bus_addr       = 8'h40;
        bus_if.bus_write_data = 32'h0;
        bus_if.bus_write_en   = 1'b1;
      end
      @(negedge pclk);
    end
    bus_if.bus_write_en = 1'b0;
    bus_if.servo_en     = 1'b0;
  endtask

  task automatic run_period(input string name, input int act_j, input int act,
                            input int e0, input int e1, input int est);
    int w0, w1;
    logic [31:0] st;
    exp_q.push_back(32'(e0));
    exp_q.push_back(32'(e1));
    if (act == 1) exp_q.push_back(32'(est));
    measure(act_j, act, w0, w1, st);
    sb_check({name, "_w0"}, 32'(w0));
    sb_check({name, "_w1"}, 32'(w1));
    if (act == 1) sb_check({name, "_status"}, st);
  endtask

  typedef struct {
    logic        wr;
    logic        en;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 27;
  vec_t vt [NV];

  initial begin
    logic [31:0] d;
    int hi;
    int up_w [5];
    int up_s [5];
    int dn_w [4];
    int dn_s [4];

    vt[0]  = '{1'b0, 1'b1, 8'h00, 32'h0, 32'd10};
    vt[1]  = '{1'b0, 1'b1, 8'h04, 32'h0, 32'd10};
    vt[2]  = '{1'b0, 1'b1, 8'h40, 32'h0, 32'd0};
    vt[3]  = '{1'b0, 1'b1, 8'h44, 32'h0, 32'd0};
    vt[4]  = '{1'b0, 1'b1, 8'h48, 32'h0, 32'd0};
    vt[5]  = '{1'b0, 1'b1, 8'h50, 32'h0, 32'd0};
    vt[6]  = '{1'b0, 1'b1, 8'h08, 32'h0, 32'd0};
    vt[7]  = '{1'b0, 1'b1, 8'hFC, 32'h0, 32'd0};
    vt[8]  = '{1'b1, 1'b1, 8'h04, 32'd5, 32'd0};
    vt[9]  = '{1'b0, 1'b1, 8'h07, 32'h0, 32'd10};
    vt[10] = '{1'b1, 1'b1, 8'h04, 32'd200, 32'd0};
    vt[11] = '{1'b0, 1'b1, 8'h04, 32'h0, 32'd40};
    vt[12] = '{1'b1, 1'b1, 8'h04, 32'h0000_011F, 32'd0};
    vt[13] = '{1'b0, 1'b1, 8'h04, 32'h0, 32'd31};
    vt[14] = '{1'b1, 1'b0, 8'h00, 32'd33, 32'd0};
    vt[15] = '{1'b0, 1'b1, 8'h00, 32'h0, 32'd10};
    vt[16] = '{1'b0, 1'b0, 8'h00, 32'h0, 32'd0};
    vt[17] = '{1'b1, 1'b1, 8'h40, 32'hFFFF_FFFC, 32'd0};
    vt[18] = '{1'b0, 1'b1, 8'h40, 32'h0, 32'd0};
    vt[19] = '{1'b1, 1'b1, 8'h50, 32'hFFFF_FFFF, 32'd0};
    vt[20] = '{1'b0, 1'b1, 8'h44, 32'h0, 32'd0};
    vt[21] = '{1'b1, 1'b1, 8'h04, 32'd10, 32'd0};
    vt[22] = '{1'b0, 1'b1, 8'h04, 32'h0, 32'd10};
    vt[23] = '{1'b1, 1'b1, 8'h00, 32'd40, 32'd0};
    vt[24] = '{1'b0, 1'b1, 8'h00, 32'h0, 32'd40};
    vt[25] = '{1'b1, 1'b1, 8'h00, 32'd10, 32'd0};
    vt[26] = '{1'b0, 1'b1, 8'h00, 32'h0, 32'd10};

    up_w = '{14, 18, 22, 23, 23};
    up_s = '{1, 1, 1, 0, 0};
    dn_w = '{19, 15, 11, 10};
    dn_s = '{1, 1, 1, 0};

    bus_if.bus_write_en   = 1'b0;
    bus_if.bus_read_en    = 1'b0;
    bus_if.servo_en       = 1'b0;
    bus_if.bus_addr       = 8'h0;
    bus_if.bus_write_data = 32'h0;

    // Reset.
    nreset = 1'b0;
    repeat (3) @(negedge pclk);
    nreset = 1'b1;

    // Idle: outputs stay low, read bus idles at zero.
    hi = 0;
    for (int c = 0; c < 300; c++) begin
      if (servo_out != '0) hi++;
      @(negedge pclk);
    end
    exp_q.push_back(32'd0);
    sb_check("idle_out_high_cycles", 32'(hi));
    exp_q.push_back(32'd0);
    #1;
    sb_check("idle_read_data", bus_if.bus_read_data);
    @(negedge pclk);

    // Register vector table.
    for (int k = 0; k < NV; k++) begin
      if (vt[k].wr) begin
        bus_write(vt[k].en, vt[k].addr, vt[k].wdata);
      end else begin
        exp_q.push_back(vt[k].exp);
        bus_read(vt[k].en, vt[k].addr, d);
        sb_check($sformatf("vec%0d_rd_%02h", k, vt[k].addr), d);
      end
    end

    // Let channel 1 settle back to 10, then STATUS is clear.
    repeat (PERIOD + 5) @(negedge pclk);
    exp_q.push_back(32'd0);
    bus_read(1'b1, 8'h48, d);
    sb_check("status_settled", d);

    // Enable channel 0 at width 25.
    wait_cnt(50);
    bus_write(1'b1, 8'h00, 32'd25);
    bus_write(1'b1, 8'h40, 32'd1);
    for (int p = 0; p < 3; p++) run_period($sformatf("en25_p%0d", p), 50, 1, 25, 0, 0);

    // Slew up 10 -> 23 with STEP=4, then back down to 10.
    wait_cnt(50);
    bus_write(1'b1, 8'h00, 32'd10);
    run_period("back_to_10", 0, 0, 10, 0, 0);
    wait_cnt(50);
    bus_write(1'b1, 8'h44, 32'd4);
    bus_write(1'b1, 8'h00, 32'd23);
    exp_q.push_back(32'd1);
    bus_read(1'b1, 8'h48, d);
    sb_check("status_pending", d);
    for (int p = 0; p < 5; p++) run_period($sformatf("slew_up_p%0d", p), 50, 1, up_w[p], 0, up_s[p]);
    bus_write(1'b1, 8'h00, 32'd10);
    for (int p = 0; p < 4; p++) run_period($sformatf("slew_dn_p%0d", p), 50, 1, dn_w[p], 0, dn_s[p]);

    // TARGET write in the boundary cycle waits one more period.
    wait_cnt(50);
    bus_write(1'b1, 8'h44, 32'd0);
    wait_cnt(99);
    bus_write(1'b1, 8'h00, 32'd30);
    run_period("bnd_write_old", 0, 0, 10, 0, 0);
    run_period("bnd_write_new", 0, 0, 30, 0, 0);

    // Clearing CTRL mid-pulse finishes the current pulse.
    bus_write(1'b1, 8'h00, 32'd25);
    run_period("pre_disable", 0, 0, 25, 0, 0);
    run_period("disable_mid", 4, 2, 25, 0, 0);
    run_period("disabled", 0, 0, 0, 0, 0);

    // Reset mid-pulse.
    bus_write(1'b1, 8'h40, 32'd1);
    run_period("reenabled", 0, 0, 25, 0, 0);
    wait_cnt(12);
    exp_q.push_back(32'd1);
    sb_check("pulse_before_reset", 32'(servo_out[0]));
    nreset = 1'b0;
    @(posedge pclk);
    #1;
    exp_q.push_back(32'd0);
    sb_check("out_after_reset", 32'(servo_out));
    @(negedge pclk);
    nreset = 1'b1;
    exp_q.push_back(32'd0);
    bus_read(1'b1, 8'h4C, d);
    sb_check("count_after_reset", d);
    exp_q.push_back(32'd1);
    bus_read(1'b1, 8'h4C, d);
    sb_check("count_next", d);
    exp_q.push_back(32'd0);
    bus_read(1'b1, 8'h40, d);
    sb_check("ctrl_after_reset", d);
    exp_q.push_back(32'd10);
    bus_read(1'b1, 8'h00, d);
    sb_check("target0_after_reset", d);
    run_period("after_reset", 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
